ctrl_pipe: RTL

- Receiving end of the instruction decoder's control interface. Takes the decoded control bundle of the instruction in ID and carries it through the ID/EX, EX/MEM and MEM/WB registers.
- Inserts bubbles on load-use hazards and on taken branches.
- Runs a halt-drain state machine when a SYSCALL/HALT is decoded.
- Sits between the decoder and the datapath pipeline registers. Drives stall and flush back to IF/ID.

---
 rtl/ctrl_pkg.sv | 39 +++
 rtl/ctrl_hazard_detect.sv | 42 ++++
 rtl/ctrl_pipe.sv | 119 +++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared control-bundle types, opcode/ALUOp constants and FSM states for ctrl_pipe
package ctrl_pkg;

   typedef struct packed {
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] alu_op;
      logic       branch;
      logic       halt;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   localparam logic [6:0] OP_R_TYPE    = 7'b0110011;
   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_IMMEDIATE = 7'b0010011;
   localparam logic [6:0] OP_SYSCALL   = 7'b1110011;

   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } pipe_state_e;

   typedef enum logic {
      SEL_ID     = 1'b0,
      SEL_BUBBLE = 1'b1
   } ex_sel_e;

endpackage

// File: rtl/ctrl_hazard_detect.sv
// rtl/ctrl_hazard_detect.sv - combinational load-use detection and EX-entry priority select
module ctrl_hazard_detect
   import ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  run_i,
   input  logic                  ex_mem_read_i,
   input  logic                  ex_branch_i,
   input  logic                  ex_branch_taken_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   output logic                  load_use_o,
   output logic                  stall_o,
   output logic                  flush_o,
   output ex_sel_e               sel_o
);

   logic taken;

   always_comb begin
      load_use_o = ex_mem_read_i && (ex_rd_i != '0) &&
                   ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
      taken      = ex_branch_i && ex_branch_taken_i;
      stall_o    = 1'b0;
      flush_o    = 1'b0;
      sel_o      = SEL_ID;
      // A taken branch outranks load-use: the ID instruction is wrong-path anyway.
      if (!run_i) begin
         stall_o = 1'b1;
         sel_o   = SEL_BUBBLE;
      end else if (taken) begin
         flush_o = 1'b1;
         sel_o   = SEL_BUBBLE;
      end else if (load_use_o) begin
         stall_o = 1'b1;
         sel_o   = SEL_BUBBLE;
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID/EX, EX/MEM, MEM/WB control registers with bubbles and halt drain (option: CTRL_PIPE_STATS_EN)
module ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5
`ifdef CTRL_PIPE_STATS_EN
   ,
   parameter int STAT_W     = 32
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  ctrl_t                 id_ctrl,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  ex_branch_taken,
   output logic                  stall,
   output logic                  flush_if_id,
   output ctrl_t                 ex_ctrl,
   output ctrl_t                 mem_ctrl,
   output ctrl_t                 wb_ctrl,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  halted
`ifdef CTRL_PIPE_STATS_EN
   ,
   output logic [STAT_W-1:0]     stall_count,
   output logic [STAT_W-1:0]     flush_count
`endif
);

   pipe_state_e           state_q, state_d;
   ctrl_t                 ex_ctrl_q, mem_ctrl_q, wb_ctrl_q, ex_ctrl_d;
   logic [REG_ADDR_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q, ex_rd_d;
   logic                  load_use;
   logic                  stall_w, flush_w;
   ex_sel_e               sel;

   ctrl_hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
      .run_i             (state_q == RUN),
      .ex_mem_read_i     (ex_ctrl_q.mem_read),
      .ex_branch_i       (ex_ctrl_q.branch),
      .ex_branch_taken_i (ex_branch_taken),
      .ex_rd_i           (ex_rd_q),
      .id_rs1_i          (id_rs1),
      .id_rs2_i          (id_rs2),
      .load_use_o        (load_use),
      .stall_o           (stall_w),
      .flush_o           (flush_w),
      .sel_o             (sel)
   );

   always_comb begin
      ex_ctrl_d = CTRL_BUBBLE;
      ex_rd_d   = '0;
      state_d   = state_q;
      if (sel == SEL_ID) begin
         ex_ctrl_d = id_ctrl;
         ex_rd_d   = id_rd;
      end
      case (state_q)
         RUN:     if (sel == SEL_ID && id_ctrl.halt) state_d = DRAIN;
         DRAIN:   if (wb_ctrl_q.halt) state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= RUN;
         ex_ctrl_q  <= CTRL_BUBBLE;
         mem_ctrl_q <= CTRL_BUBBLE;
         wb_ctrl_q  <= CTRL_BUBBLE;
         ex_rd_q    <= '0;
         mem_rd_q   <= '0;
         wb_rd_q    <= '0;
      end else begin
         state_q    <= state_d;
         ex_ctrl_q  <= ex_ctrl_d;
         mem_ctrl_q <= ex_ctrl_q;
         wb_ctrl_q  <= mem_ctrl_q;
         ex_rd_q    <= ex_rd_d;
         mem_rd_q   <= ex_rd_q;
         wb_rd_q    <= mem_rd_q;
      end
   end

`ifdef CTRL_PIPE_STATS_EN
   logic [STAT_W-1:0] stall_count_q, flush_count_q;

   // Counters saturate rather than wrap and freeze once the pipe has halted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else if (state_q != HALTED) begin
         if (stall_w && stall_count_q != '1) stall_count_q <= stall_count_q + 1'b1;
         if (flush_w && flush_count_q != '1) flush_count_q <= flush_count_q + 1'b1;
      end
   end

   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;
`endif

   assign stall       = stall_w;
   assign flush_if_id = flush_w;
   assign ex_ctrl     = ex_ctrl_q;
   assign mem_ctrl    = mem_ctrl_q;
   assign wb_ctrl     = wb_ctrl_q;
   assign ex_rd       = ex_rd_q;
   assign mem_rd      = mem_rd_q;
   assign wb_rd       = wb_rd_q;
   assign halted      = (state_q == HALTED);

endmodule
